// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - counter-based key debouncer with press/release/long-press pulses
// Long-press detection is compiled in only when KEY_DEBOUNCE_LONG_PRESS_EN is defined.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   output logic btn_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   state_t        state, state_nx;
   logic          s1, s2;
   logic [CW-1:0] cnt, cnt_nx;
   logic          level_nx, press_nx, release_nx, busy_nx;

   // Two-flop synchroniser; both stages reset to the released level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_in ^ ACTIVE_LOW;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         btn_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         btn_level     <= level_nx;
         press_pulse   <= press_nx;
         release_pulse <= release_nx;
         busy          <= busy_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = btn_level;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      case (state)
         IDLE: begin
            if (s2) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s2) begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx = PRESSED;
               level_nx = 1'b1;
               press_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         PRESSED: begin
            if (!s2) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (s2) begin
               state_nx = PRESSED;
               cnt_nx   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nx   = IDLE;
               level_nx   = 1'b0;
               release_nx = 1'b1;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
      busy_nx = (state_nx == PRESS_WAIT) || (state_nx == RELEASE_WAIT);
   end

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] lcnt, lcnt_nx;
   logic          long_fired, fired_nx, long_nx, long_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lcnt       <= '0;
         long_fired <= 1'b0;
         long_q     <= 1'b0;
      end else begin
         lcnt       <= lcnt_nx;
         long_fired <= fired_nx;
         long_q     <= long_nx;
      end
   end

   // The fired flag is re-armed only by a freshly accepted press, so a
   // release bounce that falls back into PRESSED cannot fire a second time.
   always_comb begin
      lcnt_nx  = lcnt;
      fired_nx = long_fired;
      long_nx  = 1'b0;
      if (state == PRESS_WAIT && state_nx == PRESSED) begin
         lcnt_nx  = '0;
         fired_nx = 1'b0;
      end else if (state == PRESSED && state_nx == PRESSED && !long_fired) begin
         if (lcnt == LCNT_LAST) begin
            long_nx  = 1'b1;
            fired_nx = 1'b1;
         end else begin
            lcnt_nx = lcnt + LW'(1);
         end
      end
   end

   assign long_pulse = long_q;
`else
   // Long-press detection compiled out; LONG_CYCLES is referenced only here.
   assign long_pulse = 1'b0 && (LONG_CYCLES > 0);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - table-driven, scoreboarded bench for key_debounce
// Long-press expectations follow KEY_DEBOUNCE_LONG_PRESS_EN.
`timescale 1ns/1ps
module tb_key_debounce;

   localparam int DC = 4;
   localparam int LC = 10;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, btn_in, btn_level, press_pulse, release_pulse, long_pulse, busy;
   logic rst_al, btn_al, level_al, press_al, release_al, long_al, busy_al;

   key_debounce #(.DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_level(btn_level),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .busy(busy)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)) dut_al (
      .clk(clk), .rst_n(rst_al), .btn_in(btn_al), .btn_level(level_al),
      .press_pulse(press_al), .release_pulse(release_al),
      .long_pulse(long_al), .busy(busy_al)
   );

   typedef struct packed {
      logic level;
      logic press;
      logic rel;
      logic busy;
      logic lng;
   } exp_t;

   typedef struct {
      logic btn;
      logic rst;
      exp_t exp;
   } vec_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   function void add(input logic btn, input logic rst, input logic level, input logic press,
                     input logic rel, input logic bsy, input logic lng);
      vec_t v;
      v.btn = btn;
      v.rst = rst;
      v.exp = '{level: level, press: press, rel: rel, busy: bsy, lng: lng};
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input exp_t act);
      exp_t e;
      tests++;
      if (sb.size() == 0) begin
         fails++;
         $display("FAIL %s: scoreboard empty, got %b", name, act);
      end else begin
         e = sb.pop_front();
         if (act !== e) begin
            fails++;
            $display("FAIL %s: lvl/prs/rel/busy/long got %b required %b", name, act, e);
         end
      end
   endtask

   task automatic al_step(input logic btn, input logic rst, input logic level, input logic press,
                          input logic rel, input logic bsy, input string name);
      btn_al = btn;
      rst_al = rst;
      sb.push_back('{level: level, press: press, rel: rel, busy: bsy, lng: 1'b0});
      @(posedge clk);
      @(negedge clk);
      check(name, {level_al, press_al, release_al, busy_al, long_al});
   endtask

   int b3[12] = '{1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
   int b4[14] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};

   initial begin
      rst_n  = 1'b0;
      btn_in = 1'b0;
      rst_al = 1'b0;
      btn_al = 1'b1;

      // Reset, then reset held with the key pressed.
      for (int i = 0; i < 2; i++) add(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) add(1, 0, 0, 0, 0, 0, 0);
      // Press right after reset release, then a clean release.
      for (int i = 0; i < 12; i++)
         add(1, 1, i >= 6, i == 6, 0, i >= 2 && i <= 5, 0);
      for (int i = 0; i < 10; i++)
         add(0, 1, i < 6, 0, i == 6, i >= 2 && i <= 5, 0);
      // Long hold: press at 6, long press (if enabled) 10 cycles later.
      for (int i = 0; i < 22; i++)
         add(1, 1, i >= 6, i == 6, 0, i >= 2 && i <= 5, LONG_EN && i == 16);
      // Release with a 2-cycle glitch back to pressed.
      for (int i = 0; i < 14; i++)
         add(b4[i][0], 1, i < 11, 0, i == 11,
             (i >= 2 && i <= 4) || (i >= 7 && i <= 10), 0);
      for (int i = 0; i < 2; i++) add(0, 1, 0, 0, 0, 0, 0);
      // Press bounce shorter than the debounce window.
      for (int i = 0; i < 12; i++)
         add(b3[i][0], 1, 0, 0, 0, (i == 2) || (i == 3) || (i >= 5 && i <= 7), 0);

      @(negedge clk);
      for (int i = 0; i < vecs.size(); i++) begin
         rst_n  = vecs[i].rst;
         btn_in = vecs[i].btn;
         sb.push_back(vecs[i].exp);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d", i), {btn_level, press_pulse, release_pulse, busy, long_pulse});
      end

      // Active-low key: reset, press, release, reset mid-PRESS_WAIT, re-detect.
      for (int i = 0; i < 2; i++) al_step(1, 0, 0, 0, 0, 0, $sformatf("al_rst%0d", i));
      for (int i = 0; i < 4; i++) al_step(1, 1, 0, 0, 0, 0, $sformatf("al_idle%0d", i));
      for (int i = 0; i < 10; i++)
         al_step(0, 1, i >= 6, i == 6, 0, i >= 2 && i <= 5, $sformatf("al_press%0d", i));
      for (int i = 0; i < 10; i++)
         al_step(1, 1, i < 6, 0, i == 6, i >= 2 && i <= 5, $sformatf("al_rel%0d", i));
      for (int i = 0; i < 3; i++)
         al_step(0, 1, 0, 0, 0, i == 2, $sformatf("al_wait%0d", i));
      al_step(0, 0, 0, 0, 0, 0, "al_midrst");
      for (int i = 0; i < 9; i++)
         al_step(0, 1, i >= 6, i == 6, 0, i >= 2 && i <= 5, $sformatf("al_repress%0d", i));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Counter-based debouncer for raw mechanical push-buttons. It synchronises an asynchronous key input and filters contact bounce with a four-state machine. It then delivers a clean debounced level plus single-cycle press and release pulses. It sits directly upstream of the button edge-detection logic and the control FSMs that consume key events.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: number of consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥1.
- `LONG_CYCLES`, default 50000000: number of cycles held in the pressed state before the long-press event fires; legal range ≥1; only used with the macro.
- `ACTIVE_LOW`, default 0: 1 means the raw key reads 0 when pressed; the input is inverted before filtering.

- `clk` input, 1 bit: system clock; single clock domain.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `btn_in` input, 1 bit: raw asynchronous key.
- `btn_level` output, 1 bit: debounced level, 1 = pressed.
- `press_pulse` output, 1 bit: one-cycle pulse when a press is accepted.
- `release_pulse` output, 1 bit: one-cycle pulse when a release is accepted.
- `long_pulse` output, 1 bit: one-cycle pulse on long press; the port is always present.
- `busy` output, 1 bit: high while in PRESS_WAIT or RELEASE_WAIT.

## Operation
- **Input normalisation and synchronisation**
  - `btn_in` is XORed with `ACTIVE_LOW`.
  - It then passes through two flops, s1 then s2. Only s2 is used downstream.
  - Both flops reset to 0, the released level.
- **Counter width**: `cnt` is $clog2(DEBOUNCE_CYCLES+1) bits; `lcnt` is $clog2(LONG_CYCLES+1) bits. Neither counter ever wraps.
- **IDLE** (released, `btn_level`=0)
  - s2=1 → PRESS_WAIT, `cnt`←0.
- **PRESS_WAIT**
  - s2=0 → IDLE, `cnt`←0, no pulse.
  - s2=1 and `cnt`==DEBOUNCE_CYCLES−1 → PRESSED; `btn_level`←1, `press_pulse`←1, `lcnt`←0, long-fired flag cleared.
  - Otherwise `cnt`←`cnt`+1.
- **PRESSED**
  - s2=0 → RELEASE_WAIT, `cnt`←0.
  - Otherwise long-press counting runs (macro only).
- **RELEASE_WAIT**
  - s2=1 → PRESSED, `cnt`←0, no pulse, `lcnt` retained.
  - s2=0 and `cnt`==DEBOUNCE_CYCLES−1 → IDLE; `btn_level`←0, `release_pulse`←1.
  - Otherwise increment `cnt`.
- **Pulse rules**
  - All outputs are registered.
  - Each pulse is high for exactly one cycle.
  - `press_pulse` and `release_pulse` are never high in the same cycle.
  - A bounce shorter than DEBOUNCE_CYCLES produces no pulse and no change of `btn_level`.
- **Reset mid-operation**: state returns to IDLE and all counters clear. A key still held after reset is detected again as a fresh press after a full debounce.

## Timing
- **Reset values**: all outputs are 0 and the state is IDLE.
- **Press/release latency**, with edge 0 being the first clock edge at which s1 captures the new stable level:
  - s2 updates at edge 1.
  - The wait state is entered at edge 2.
  - `btn_level` and the pulse update at edge DEBOUNCE_CYCLES+2.
- **Long press**: with PRESSED entered at edge E, `long_pulse` rises at edge E+LONG_CYCLES.
- **Simultaneous events**: `long_pulse` can never coincide with `press_pulse`. With LONG_CYCLES=1 it follows one cycle after.
- **Throughput**: there is no handshake. Consumers must sample the pulses every cycle.

## Configuration
- **Macro**: `KEY_DEBOUNCE_LONG_PRESS_EN`.
- **Defined**
  - `lcnt` increments every cycle in PRESSED while the long-fired flag is 0.
  - At `lcnt`==LONG_CYCLES−1: `long_pulse`←1, flag←1, and `lcnt` holds.
  - One `long_pulse` fires per accepted press.
  - A brief release bounce that returns to PRESSED does not re-arm the flag.
- **Not defined**
  - `long_pulse` is tied to 0.
  - The `lcnt` logic is absent and `LONG_CYCLES` is ignored.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=10 and ACTIVE_LOW=0 unless stated otherwise.

1. Hold `rst_n`=0 for 3 cycles with `btn_in`=1 → all outputs 0 throughout. After release, `press_pulse` fires at edge 6 counted from the first post-reset edge.
2. Step `btn_in` 0→1 and hold for 20 cycles → `press_pulse` high exactly one cycle at edge 6; `btn_level`=1 from edge 6; `busy` high for edges 2–5.
3. Bounce pattern 1,1,0,1,1,1,0 (one value per cycle), then 0 → no pulses and `btn_level` stays 0.
4. From PRESSED, step to 0 with one 2-cycle glitch back to 1 → `release_pulse` fires only 6 edges after the final stable 0, exactly once.
5. Macro defined, hold for 30 cycles → `long_pulse` once, 10 cycles after `press_pulse`. Macro undefined → `long_pulse` stays 0.
6. ACTIVE_LOW=1: `btn_in` 1→0 gives `press_pulse` at edge 6. Asserting `rst_n` low mid-PRESS_WAIT gives `busy`=0 and no pulse.
